// File: rtl/snake_body.sv
// snake_body: snake segment list, movement, growth, collision and pixel lookup.
// Define SNAKE_WRAP_EN to make walls wrap instead of killing the snake.
module snake_body #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_tick,
  input  logic [1:0] dir,
  input  logic       grow,
  input  logic       restart,
  input  logic [8:0] row,
  input  logic [9:0] col,
  output logic       snake_r,
  output logic       snake_head,
  output logic [5:0] head_x,
  output logic [4:0] head_y,
  output logic [5:0] length,
  output logic       dead
);

  localparam logic [1:0] D_UP = 2'd0;
  localparam logic [1:0] D_DN = 2'd1;
  localparam logic [1:0] D_LT = 2'd2;
  localparam logic [1:0] D_RT = 2'd3;

  localparam logic [5:0] MAXL  = 6'(MAX_LEN);
  localparam logic [5:0] INITL = 6'(INIT_LEN);
  localparam logic [5:0] GW1   = 6'(GRID_W - 1);
  localparam logic [4:0] GH1   = 5'(GRID_H - 1);
  localparam logic [5:0] X0    = 6'd20;
  localparam logic [4:0] Y0    = 5'd15;

  typedef enum logic {
    S_RUN,
    S_DEAD
  } state_e;

  typedef struct packed {
    logic [5:0] x;
    logic [4:0] y;
  } cell_t;

  state_e     state_q, state_d;
  cell_t      seg_q [MAX_LEN];
  cell_t      seg_d [MAX_LEN];
  logic [5:0] len_q, len_d;
  logic [1:0] dir_q, dir_d;
  logic       grow_q, grow_d;
  logic       body_q, body_d;
  logic       head_q, head_d;

  logic       run;
  logic       step;
  logic       growing;
  logic       wall;
  logic       wall_kill;
  logic       self_hit;
  logic       hit;
  logic       mv;
  logic [1:0] new_dir;
  logic [5:0] lim;
  cell_t      nh;
  cell_t      pc;
  logic       in_rng;
  logic       body;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:  if (restart) state_d = S_RUN;
              else if (hit) state_d = S_DEAD;
      S_DEAD: if (restart) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    run  = (state_q == S_RUN);
    dead = (state_q == S_DEAD);
  end

  // ---------------- next head ----------------
  always_comb begin
    new_dir = ((dir ^ dir_q) == 2'b01) ? dir_q : dir;
    nh      = seg_q[0];
    wall    = 1'b0;
    unique case (1'b1)
      (new_dir == D_UP): begin
        wall = (seg_q[0].y == 5'd0);
        nh.y = wall ? GH1 : seg_q[0].y - 5'd1;
      end
      (new_dir == D_DN): begin
        wall = (seg_q[0].y == GH1);
        nh.y = wall ? 5'd0 : seg_q[0].y + 5'd1;
      end
      (new_dir == D_LT): begin
        wall = (seg_q[0].x == 6'd0);
        nh.x = wall ? GW1 : seg_q[0].x - 6'd1;
      end
      (new_dir == D_RT): begin
        wall = (seg_q[0].x == GW1);
        nh.x = wall ? 6'd0 : seg_q[0].x + 6'd1;
      end
      default: ;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign wall_kill = 1'b0;
`else
  assign wall_kill = wall;
`endif

  assign growing = (grow_q | grow) & (len_q != MAXL);
  assign lim     = growing ? len_q : len_q - 6'd1;

  // The vacating tail only blocks the head when it stays put (growth).
  always_comb begin
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((6'(i) < lim) && (seg_q[i] == nh)) begin
        self_hit = 1'b1;
      end
    end
  end

  assign step = run & move_tick & ~restart;
  assign hit  = step & (wall_kill | self_hit);
  assign mv   = step & ~hit;

  // ---------------- game state ----------------
  always_comb begin
    seg_d  = seg_q;
    len_d  = len_q;
    dir_d  = dir_q;
    grow_d = grow_q;
    if (restart) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_d[i] = {X0 - 6'(i), Y0};
      end
      len_d  = INITL;
      dir_d  = D_RT;
      grow_d = 1'b0;
    end else if (run) begin
      if (mv) begin
        seg_d[0] = nh;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_d[i] = seg_q[i-1];
        end
        dir_d  = new_dir;
        grow_d = 1'b0;
        if (growing) len_d = len_q + 6'd1;
      end else if (grow) begin
        grow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= {X0 - 6'(i), Y0};
      end
      len_q  <= INITL;
      dir_q  <= D_RT;
      grow_q <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_q[i] <= seg_d[i];
      end
      len_q  <= len_d;
      dir_q  <= dir_d;
      grow_q <= grow_d;
    end
  end

  // ---------------- pixel lookup ----------------
  assign pc     = {col[9:4], row[8:4]};
  assign in_rng = (col < 10'd640) && (row < 9'd480);

  always_comb begin
    body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((6'(i) < len_q) && (seg_q[i] == pc)) begin
        body = 1'b1;
      end
    end
    head_d = in_rng && (pc == seg_q[0]);
    body_d = in_rng && body && !head_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      body_q <= 1'b0;
      head_q <= 1'b0;
    end else begin
      body_q <= body_d;
      head_q <= head_d;
    end
  end

  assign snake_r    = body_q;
  assign snake_head = head_q;
  assign head_x     = seg_q[0].x;
  assign head_y     = seg_q[0].y;
  assign length     = len_q;

endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed vectors and sequences plus randomized play
// checked against a queue-based model of the snake.
module tb_snake_body;

  localparam int MAX_LEN  = 32;
  localparam int INIT_LEN = 3;
  localparam int GW       = 40;
  localparam int GH       = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       move_tick = 1'b0;
  logic [1:0] dir = 2'd3;
  logic       grow = 1'b0;
  logic       restart = 1'b0;
  logic [8:0] row = '0;
  logic [9:0] col = '0;
  logic       snake_r;
  logic       snake_head;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [5:0] length;
  logic       dead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_body #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .GRID_W  (GW),
    .GRID_H  (GH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move_tick (move_tick),
    .dir       (dir),
    .grow      (grow),
    .restart   (restart),
    .row       (row),
    .col       (col),
    .snake_r   (snake_r),
    .snake_head(snake_head),
    .head_x    (head_x),
    .head_y    (head_y),
    .length    (length),
    .dead      (dead)
  );

  typedef struct {
    int row;
    int col;
    int er;
    int eh;
  } pv_t;

  pv_t tbl [8];

  // ---------------- reference model ----------------
  int mx[$];
  int my[$];
  int mdir;
  bit mgp;
  bit mdead;

  function automatic void m_init();
    mx.delete();
    my.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      mx.push_back(20 - i);
      my.push_back(15);
    end
    mdir  = 3;
    mgp   = 1'b0;
    mdead = 1'b0;
  endfunction

  function automatic bit opposite(input int a, input int b);
    return (a == 0 && b == 1) || (a == 1 && b == 0) ||
           (a == 2 && b == 3) || (a == 3 && b == 2);
  endfunction

  function automatic void m_step(input bit t, input int d,
                                 input bit g, input bit r);
    int nd, nx, ny, n;
    bit wl, hit, growing;
    if (r) begin
      m_init();
      return;
    end
    if (mdead) return;
    if (g) mgp = 1'b1;
    if (!t) return;
    nd = opposite(d, mdir) ? mdir : d;
    nx = mx[0];
    ny = my[0];
    case (nd)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
    wl = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
    wl = 1'b0;
`endif
    growing = mgp && (mx.size() < MAX_LEN);
    n = growing ? mx.size() : mx.size() - 1;
    hit = wl;
    for (int i = 0; i < n; i++) begin
      if (mx[i] == nx && my[i] == ny) hit = 1'b1;
    end
    if (hit) begin
      mdead = 1'b1;
      return;
    end
    mdir = nd;
    mx.push_front(nx);
    my.push_front(ny);
    if (!growing) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    mgp = 1'b0;
  endfunction

  function automatic void m_pix(input int c, input int r,
                                output int b, output int h);
    int cx, cy;
    b = 0;
    h = 0;
    if (c >= 640 || r >= 480) return;
    cx = c / 16;
    cy = r / 16;
    h = (mx[0] == cx && my[0] == cy) ? 1 : 0;
    for (int i = 1; i < mx.size(); i++) begin
      if (h == 0 && mx[i] == cx && my[i] == cy) b = 1;
    end
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [1:0] d, input bit g);
    dir       = d;
    move_tick = 1'b1;
    grow      = g;
    cyc();
    move_tick = 1'b0;
    grow      = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
  endtask

  initial begin
    tbl[0] = '{row: 240, col: 320, er: 0, eh: 1};
    tbl[1] = '{row: 240, col: 304, er: 1, eh: 0};
    tbl[2] = '{row: 240, col: 270, er: 0, eh: 0};
    tbl[3] = '{row: 255, col: 295, er: 1, eh: 0};
    tbl[4] = '{row: 255, col: 335, er: 0, eh: 1};
    tbl[5] = '{row: 256, col: 320, er: 0, eh: 0};
    tbl[6] = '{row: 240, col: 640, er: 0, eh: 0};
    tbl[7] = '{row: 480, col: 320, er: 0, eh: 0};

    // reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_head_x", head_x, 20);
    chk("rst_head_y", head_y, 15);
    chk("rst_length", length, INIT_LEN);
    chk("rst_dead", dead, 0);
    chk("rst_snake_r", snake_r, 0);
    chk("rst_snake_head", snake_head, 0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // pixel lookup table
    for (int i = 0; i < 8; i++) begin
      row = 9'(tbl[i].row);
      col = 10'(tbl[i].col);
      cyc();
      chk($sformatf("pix%0d_r", i), snake_r, tbl[i].er);
      chk($sformatf("pix%0d_h", i), snake_head, tbl[i].eh);
    end

    // move and reversal
    tick(2'd3, 1'b0);
    chk("mv_x", head_x, 21);
    tick(2'd2, 1'b0);
    chk("rev_x", head_x, 22);
    chk("rev_y", head_y, 15);
    chk("rev_dead", dead, 0);

    // growth
    do_restart();
    chk("rs_x", head_x, 20);
    grow = 1'b1;
    cyc();
    grow = 1'b0;
    repeat (3) cyc();
    chk("pend_len", length, 3);
    tick(2'd3, 1'b0);
    chk("grow_len", length, 4);
    col = 10'd288;
    row = 9'd240;
    cyc();
    chk("grow_tail", snake_r, 1);
    tick(2'd3, 1'b1);
    chk("grow2_len", length, 5);
    chk("grow2_x", head_x, 22);

    // self-collision
    tick(2'd3, 1'b0);
    tick(2'd1, 1'b0);
    tick(2'd2, 1'b0);
    chk("self_pre_dead", dead, 0);
    tick(2'd0, 1'b0);
    chk("self_dead", dead, 1);
    chk("self_x", head_x, 22);
    chk("self_y", head_y, 16);
    chk("self_len", length, 5);
    tick(2'd3, 1'b0);
    chk("dead_hold_x", head_x, 22);

    // restart beats move_tick and grow
    restart   = 1'b1;
    move_tick = 1'b1;
    grow      = 1'b1;
    dir       = 2'd0;
    cyc();
    restart   = 1'b0;
    move_tick = 1'b0;
    grow      = 1'b0;
    chk("rsmv_x", head_x, 20);
    chk("rsmv_y", head_y, 15);
    chk("rsmv_dead", dead, 0);
    chk("rsmv_len", length, 3);
    tick(2'd3, 1'b0);
    chk("rsmv_nogrow", length, 3);
    chk("rsmv_x2", head_x, 21);

    // wall
    do_restart();
    for (int i = 0; i < 15; i++) tick(2'd0, 1'b0);
    chk("wall_y0", head_y, 0);
    chk("wall_alive", dead, 0);
    tick(2'd0, 1'b0);
`ifdef SNAKE_WRAP_EN
    chk("wrap_y", head_y, 29);
    chk("wrap_dead", dead, 0);
`else
    chk("wall_dead", dead, 1);
    chk("wall_y", head_y, 0);
    tick(2'd0, 1'b0);
    chk("wall_hold_y", head_y, 0);
    chk("wall_hold_dead", dead, 1);
`endif

    // mid-game asynchronous reset
    do_restart();
    tick(2'd3, 1'b0);
    tick(2'd3, 1'b0);
    col = 10'(22 * 16 + 5);
    row = 9'(15 * 16 + 3);
    cyc();
    chk("mid_head_pix", snake_head, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", head_x, 20);
    chk("mid_rst_len", length, 3);
    chk("mid_rst_pix", snake_head, 0);
    chk("mid_rst_dead", dead, 0);
    #2 rst_n = 1'b1;
    cyc();
    chk("mid_after_h", snake_head, 0);
    chk("mid_after_r", snake_r, 0);

    // randomized play against the model
    do_restart();
    m_init();
    for (int k = 0; k < 3000; k++) begin
      bit t, g, r;
      int d, c, rw, j, eb, eh;
      t = ($urandom_range(3) == 0);
      g = ($urandom_range(4) == 0);
      r = mdead ? ($urandom_range(5) == 0) : ($urandom_range(299) == 0);
      d = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : mdir;
      if ($urandom_range(1) == 1) begin
        j  = int'($urandom_range(mx.size() - 1));
        c  = mx[j] * 16 + int'($urandom_range(15));
        rw = my[j] * 16 + int'($urandom_range(15));
      end else begin
        c  = int'($urandom_range(1023));
        rw = int'($urandom_range(511));
      end
      m_pix(c, rw, eb, eh);
      move_tick = t;
      grow      = g;
      restart   = r;
      dir       = 2'(d);
      col       = 10'(c);
      row       = 9'(rw);
      cyc();
      move_tick = 1'b0;
      grow      = 1'b0;
      restart   = 1'b0;
      m_step(t, d, g, r);
      chk("rnd_snake_r", snake_r, eb);
      chk("rnd_snake_head", snake_head, eh);
      chk("rnd_head_x", head_x, mx[0]);
      chk("rnd_head_y", head_y, my[0]);
      chk("rnd_length", length, mx.size());
      chk("rnd_dead", dead, mdead);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
